pkt_mem_responder: RTL and testbench

// Byte-addressed packet/argument memory; the responder side of the executor/cksum memory bus (ce/we/addr/width/data).

---
 rtl/pkt_mem_responder_pkg.sv | 25 ++
 rtl/pkt_mem_responder_if.sv | 23 ++
 rtl/pkt_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_pkt_mem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_mem_responder_pkg.sv
// Shared types and constants for the packet memory responder slice.
package pkt_mem_responder_pkg;

   localparam int PM_DEPTH     = 256;
   localparam int PM_LANES     = 4;
   localparam int PM_STATE_BUS = 2;
   localparam int ADDR_BUS     = 32;
   localparam int DATA_BUS     = 32;

   localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;
   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [PM_STATE_BUS-1:0] {
      PM_STATE_IDLE = 2'd0,
      PM_STATE_LOAD = 2'd1,
      PM_STATE_DUMP = 2'd2
   } pmState_e;

   // A bus access is well formed only for widths of one to four bytes.
   function automatic logic widthLegal(input logic [3:0] width);
      return (width != 4'd0) && (width <= 4'(PM_LANES));
   endfunction

endpackage

// File: rtl/pkt_mem_responder_if.sv
// Executor/checksum memory bus: byte address, 1..4 byte width, right-aligned data.
interface pkt_mem_responder_if;
   import pkt_mem_responder_pkg::*;

   logic                ce;
   logic                we;
   logic [ADDR_BUS-1:0] addr;
   logic [3:0]          width;
   logic [DATA_BUS-1:0] wdata;
   logic [DATA_BUS-1:0] rdata;
   logic                err;

   modport master (
      output ce, we, addr, width, wdata,
      input  rdata, err
   );

   modport slave (
      input  ce, we, addr, width, wdata,
      output rdata, err
   );

endinterface

// File: rtl/pkt_mem_responder.sv
// Byte-addressed packet memory: big-endian bus responder, ingress loader and egress dumper.
module pkt_mem_responder
   import pkt_mem_responder_pkg::*;
#(
   parameter int DEPTH  = PM_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
)
(
   input  logic              clk,
   input  logic              rst,
   pkt_mem_responder_if.slave mem,
   input  logic              in_valid_i,
   input  logic [7:0]        in_data_i,
   input  logic              in_last_i,
   output logic              in_ready_o,
   input  logic              dump_start_i,
   output logic              out_valid_o,
   output logic [7:0]        out_data_o,
   output logic              out_last_o,
   input  logic              out_ready_i,
   output logic [ADDR_W:0]   pkt_len_o,
   output logic              trunc_o,
   output logic              busy_o
);

   localparam logic [ADDR_BUS:0] DEPTH_EXT = (ADDR_BUS+1)'(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   pmState_e            state_q;
   logic [7:0]          bytes_q [DEPTH];
   logic [ADDR_W:0]     pktLen_q;
   logic [ADDR_W:0]     rdPtr_q;
   logic                inReady_q;
   logic                outValid_q;
   logic                outLast_q;
   logic [7:0]          outData_q;
   logic                trunc_q;
   logic                busy_q;
   logic [DATA_BUS-1:0] memData_q;
   logic                memErr_q;

   logic [ADDR_BUS:0]   laneSum   [PM_LANES];
   logic [ADDR_W-1:0]   laneIdx   [PM_LANES];
   logic [4:0]          laneShift [PM_LANES];
   logic [7:0]          laneByte  [PM_LANES];
   logic [PM_LANES-1:0] laneHit;
   logic [DATA_BUS-1:0] laneRdData_d;
   logic                laneErr_d;

   logic                busLegal;
   logic                busWrEn;
   logic                inAccept;
   logic                loadWe;
   logic [ADDR_W-1:0]   loadIdx;
   logic                dumpGo;
   logic                outFire;

   assign busLegal = widthLegal(mem.width);
   assign busWrEn  = !rst && mem.ce && mem.we && !busy_q && busLegal;
   assign inAccept = in_valid_i && inReady_q && (state_q != PM_STATE_DUMP);
   assign loadWe   = !rst && inAccept &&
                     ((state_q == PM_STATE_IDLE) || (pktLen_q < DEPTH_CNT));
   assign loadIdx  = (state_q == PM_STATE_IDLE) ? '0 : pktLen_q[ADDR_W-1:0];
   assign dumpGo   = dump_start_i && !in_valid_i && (pktLen_q != '0);
   assign outFire  = outValid_q && out_ready_i;

   // Split a bus access into byte lanes: address range per lane, gathered read data and write bytes.
   always_comb begin
      laneRdData_d = '0;
      laneErr_d    = FALSE;
      laneHit      = '0;
      for (int k = 0; k < PM_LANES; k++) begin
         laneSum[k]   = {1'b0, mem.addr} + (ADDR_BUS+1)'(k);
         laneIdx[k]   = laneSum[k][ADDR_W-1:0];
         laneShift[k] = '0;
         laneByte[k]  = '0;
         if (k < int'(mem.width)) begin
            laneShift[k] = 5'((int'(mem.width) - 1 - k) * 8);
            laneByte[k]  = 8'(mem.wdata >> laneShift[k]);
            if (laneSum[k] < DEPTH_EXT) begin
               laneHit[k]   = TRUE;
               laneRdData_d = {laneRdData_d[DATA_BUS-9:0], bytes_q[laneIdx[k]]};
            end else begin
               laneErr_d    = TRUE;
               laneRdData_d = {laneRdData_d[DATA_BUS-9:0], 8'h00};
            end
         end
      end
   end

   // Byte storage; an ingress byte landing on the same cycle as a bus write takes precedence.
   always_ff @(posedge clk) begin
      if (busWrEn) begin
         for (int k = 0; k < PM_LANES; k++) begin
            if (laneHit[k]) begin
               bytes_q[laneIdx[k]] <= laneByte[k];
            end
         end
      end
      if (loadWe) begin
         bytes_q[loadIdx] <= in_data_i;
      end
   end

   // Bus response: registered read data and error flag for the previous access.
   always_ff @(posedge clk) begin
      if (rst) begin
         memData_q <= ZERO_WORD;
         memErr_q  <= FALSE;
      end else if (!mem.ce) begin
         memErr_q  <= FALSE;
      end else if (busy_q || !busLegal) begin
         memData_q <= ZERO_WORD;
         memErr_q  <= TRUE;
      end else if (!mem.we) begin
         memData_q <= laneRdData_d;
         memErr_q  <= laneErr_d;
      end else begin
         memErr_q  <= laneErr_d;
      end
   end

   // Load/dump sequencer with its registered stream outputs, length and truncation flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PM_STATE_IDLE;
         inReady_q  <= FALSE;
         outValid_q <= FALSE;
         outLast_q  <= FALSE;
         outData_q  <= '0;
         pktLen_q   <= '0;
         rdPtr_q    <= '0;
         trunc_q    <= FALSE;
         busy_q     <= FALSE;
      end else begin
         case (state_q)
            PM_STATE_IDLE: begin
               inReady_q <= TRUE;
               if (inAccept) begin
                  pktLen_q <= (ADDR_W+1)'(1);
                  trunc_q  <= FALSE;
                  if (!in_last_i) begin
                     state_q <= PM_STATE_LOAD;
                     busy_q  <= TRUE;
                  end
               end else if (dumpGo) begin
                  state_q    <= PM_STATE_DUMP;
                  busy_q     <= TRUE;
                  inReady_q  <= FALSE;
                  outValid_q <= TRUE;
                  outData_q  <= bytes_q[0];
                  outLast_q  <= (pktLen_q == (ADDR_W+1)'(1));
                  rdPtr_q    <= (ADDR_W+1)'(1);
               end
            end
            PM_STATE_LOAD: begin
               if (inAccept) begin
                  if (pktLen_q < DEPTH_CNT) begin
                     pktLen_q <= pktLen_q + 1'b1;
                  end else begin
                     trunc_q <= TRUE;
                  end
                  if (in_last_i) begin
                     state_q <= PM_STATE_IDLE;
                     busy_q  <= FALSE;
                  end
               end
            end
            PM_STATE_DUMP: begin
               if (outFire) begin
                  if (outLast_q) begin
                     state_q    <= PM_STATE_IDLE;
                     busy_q     <= FALSE;
                     inReady_q  <= TRUE;
                     outValid_q <= FALSE;
                     outLast_q  <= FALSE;
                  end else begin
                     outData_q <= bytes_q[rdPtr_q[ADDR_W-1:0]];
                     outLast_q <= (rdPtr_q == (pktLen_q - 1'b1));
                     rdPtr_q   <= rdPtr_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= PM_STATE_IDLE;
               busy_q  <= FALSE;
            end
         endcase
      end
   end

   assign mem.rdata   = memData_q;
   assign mem.err     = memErr_q;
   assign in_ready_o  = inReady_q;
   assign out_valid_o = outValid_q;
   assign out_data_o  = outData_q;
   assign out_last_o  = outLast_q;
   assign pkt_len_o   = pktLen_q;
   assign trunc_o     = trunc_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_pkt_mem_responder.sv
// Directed self-checking bench for pkt_mem_responder (DEPTH = 256).
module tb_pkt_mem_responder;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   logic              clk;
   logic              rst;
   logic              in_valid_i;
   logic [7:0]        in_data_i;
   logic              in_last_i;
   logic              in_ready_o;
   logic              dump_start_i;
   logic              out_valid_o;
   logic [7:0]        out_data_o;
   logic              out_last_o;
   logic              out_ready_i;
   logic [ADDR_W:0]   pkt_len_o;
   logic              trunc_o;
   logic              busy_o;

   int compared   = 0;
   int mismatched = 0;
   int idx;
   int cyc;

   pkt_mem_responder_if memBus ();

   pkt_mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem          (memBus),
      .in_valid_i   (in_valid_i),
      .in_data_i    (in_data_i),
      .in_last_i    (in_last_i),
      .in_ready_o   (in_ready_o),
      .dump_start_i (dump_start_i),
      .out_valid_o  (out_valid_o),
      .out_data_o   (out_data_o),
      .out_last_o   (out_last_o),
      .out_ready_i  (out_ready_i),
      .pkt_len_o    (pkt_len_o),
      .trunc_o      (trunc_o),
      .busy_o       (busy_o)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Present one bus access for a single cycle, then release the enable.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] width,
                                input logic [31:0] data);
      memBus.ce    = 1'b1;
      memBus.we    = we;
      memBus.addr  = addr;
      memBus.width = width;
      memBus.wdata = data;
      tick();
      memBus.ce    = 1'b0;
      memBus.we    = 1'b0;
   endtask

   // Directed sequence.
   initial begin
      rst          = 1'b1;
      memBus.ce    = 1'b0;
      memBus.we    = 1'b0;
      memBus.addr  = '0;
      memBus.width = '0;
      memBus.wdata = '0;
      in_valid_i   = 1'b0;
      in_data_i    = '0;
      in_last_i    = 1'b0;
      dump_start_i = 1'b0;
      out_ready_i  = 1'b0;
      tick();
      tick();

      checkOutput("rst_mem_data",  memBus.rdata, 32'h0);
      checkOutput("rst_mem_err",   memBus.err,   32'h0);
      checkOutput("rst_in_ready",  in_ready_o,   32'h0);
      checkOutput("rst_out_valid", out_valid_o,  32'h0);
      checkOutput("rst_out_last",  out_last_o,   32'h0);
      checkOutput("rst_out_data",  out_data_o,   32'h0);
      checkOutput("rst_pkt_len",   pkt_len_o,    32'h0);
      checkOutput("rst_trunc",     trunc_o,      32'h0);
      checkOutput("rst_busy",      busy_o,       32'h0);

      rst = 1'b0;
      tick();
      checkOutput("idle_in_ready", in_ready_o, 32'h1);

      // Big-endian write and reads of varying width.
      applyStimulus(1'b1, 32'd14, 4'd2, 32'h0000ABCD);
      checkOutput("wr14_err",  memBus.err,   32'h0);
      checkOutput("wr14_hold", memBus.rdata, 32'h0);
      applyStimulus(1'b0, 32'd14, 4'd2, 32'h0);
      checkOutput("rd14w2",     memBus.rdata, 32'h0000ABCD);
      checkOutput("rd14w2_err", memBus.err,   32'h0);
      applyStimulus(1'b0, 32'd14, 4'd1, 32'h0);
      checkOutput("rd14w1", memBus.rdata, 32'h000000AB);
      applyStimulus(1'b0, 32'd15, 4'd1, 32'h0);
      checkOutput("rd15w1", memBus.rdata, 32'h000000CD);

      // Access straddling the top of memory, then illegal widths.
      applyStimulus(1'b1, DEPTH - 2, 4'd2, 32'h00001122);
      applyStimulus(1'b0, DEPTH - 2, 4'd4, 32'h0);
      checkOutput("rd_top_data", memBus.rdata, 32'h11220000);
      checkOutput("rd_top_err",  memBus.err,   32'h1);
      applyStimulus(1'b0, 32'd0, 4'd5, 32'h0);
      checkOutput("w5_data", memBus.rdata, 32'h0);
      checkOutput("w5_err",  memBus.err,   32'h1);
      applyStimulus(1'b0, 32'd14, 4'd2, 32'h0);
      applyStimulus(1'b0, 32'd0, 4'd0, 32'h0);
      checkOutput("w0_data", memBus.rdata, 32'h0);
      checkOutput("w0_err",  memBus.err,   32'h1);
      tick();
      checkOutput("idle_err_clear", memBus.err,   32'h0);
      checkOutput("idle_data_hold", memBus.rdata, 32'h0);

      // Load a 60-byte packet 0x00..0x3B.
      for (int i = 0; i < 60; i++) begin
         in_valid_i = 1'b1;
         in_data_i  = 8'(i);
         in_last_i  = (i == 59);
         tick();
         if (i == 0) checkOutput("load_busy", busy_o, 32'h1);
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      checkOutput("load60_len",   pkt_len_o,  32'd60);
      checkOutput("load60_trunc", trunc_o,    32'h0);
      checkOutput("load60_busy",  busy_o,     32'h0);
      checkOutput("load60_ready", in_ready_o, 32'h1);
      applyStimulus(1'b0, 32'd0, 4'd4, 32'h0);
      checkOutput("load60_rd0", memBus.rdata, 32'h00010203);

      // Dump with out_ready toggling 1,0,1,0...
      dump_start_i = 1'b1;
      tick();
      dump_start_i = 1'b0;
      checkOutput("dump_first_valid", out_valid_o, 32'h1);
      checkOutput("dump_busy",        busy_o,      32'h1);
      checkOutput("dump_in_ready",    in_ready_o,  32'h0);
      idx = 0;
      cyc = 0;
      while (idx < 60 && cyc < 400) begin
         checkOutput("dump_valid", out_valid_o, 32'h1);
         checkOutput("dump_data",  out_data_o,  32'(idx));
         checkOutput("dump_last",  out_last_o,  32'(idx == 59));
         out_ready_i = ((cyc % 2) == 0);
         tick();
         if (out_ready_i) idx++;
         cyc++;
      end
      out_ready_i = 1'b0;
      checkOutput("dump_count",      idx,         32'd60);
      checkOutput("dump_done_valid", out_valid_o, 32'h0);
      checkOutput("dump_done_busy",  busy_o,      32'h0);
      checkOutput("dump_done_len",   pkt_len_o,   32'd60);

      // Second dump: bus access while busy, then reset at byte 10.
      dump_start_i = 1'b1;
      tick();
      dump_start_i = 1'b0;
      applyStimulus(1'b0, 32'd0, 4'd4, 32'h0);
      checkOutput("busy_rd_data",  memBus.rdata, 32'h0);
      checkOutput("busy_rd_err",   memBus.err,   32'h1);
      checkOutput("busy_stall",    out_data_o,   32'h0);
      out_ready_i = 1'b1;
      cyc = 0;
      while (out_data_o != 8'd10 && cyc < 50) begin
         tick();
         cyc++;
      end
      checkOutput("dump_at10", out_data_o, 32'd10);
      rst = 1'b1;
      tick();
      checkOutput("mid_rst_valid", out_valid_o, 32'h0);
      checkOutput("mid_rst_busy",  busy_o,      32'h0);
      checkOutput("mid_rst_len",   pkt_len_o,   32'h0);
      checkOutput("mid_rst_last",  out_last_o,  32'h0);
      rst         = 1'b0;
      out_ready_i = 1'b0;
      tick();

      // Dump request with an empty packet does nothing.
      dump_start_i = 1'b1;
      tick();
      dump_start_i = 1'b0;
      checkOutput("empty_dump_valid", out_valid_o, 32'h0);
      checkOutput("empty_dump_busy",  busy_o,      32'h0);

      // Oversized packet: DEPTH+3 bytes, tail marked 0xEE and dropped.
      for (int i = 0; i < DEPTH + 3; i++) begin
         in_valid_i = 1'b1;
         in_data_i  = (i < DEPTH) ? 8'(i) : 8'hEE;
         in_last_i  = (i == DEPTH + 2);
         checkOutput("big_ready", in_ready_o, 32'h1);
         tick();
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      checkOutput("big_len",   pkt_len_o, 32'(DEPTH));
      checkOutput("big_trunc", trunc_o,   32'h1);
      checkOutput("big_busy",  busy_o,    32'h0);
      applyStimulus(1'b0, DEPTH - 4, 4'd4, 32'h0);
      checkOutput("big_rd_top", memBus.rdata, 32'hFCFDFEFF);
      applyStimulus(1'b0, 32'd0, 4'd4, 32'h0);
      checkOutput("big_rd_low", memBus.rdata, 32'h00010203);

      // One-byte packet clears truncation and dumps a single last byte.
      in_valid_i = 1'b1;
      in_data_i  = 8'h77;
      in_last_i  = 1'b1;
      tick();
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      checkOutput("one_len",   pkt_len_o, 32'd1);
      checkOutput("one_trunc", trunc_o,   32'h0);
      checkOutput("one_busy",  busy_o,    32'h0);
      dump_start_i = 1'b1;
      tick();
      dump_start_i = 1'b0;
      checkOutput("one_valid", out_valid_o, 32'h1);
      checkOutput("one_data",  out_data_o,  32'h77);
      checkOutput("one_last",  out_last_o,  32'h1);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      checkOutput("one_done_valid", out_valid_o, 32'h0);
      checkOutput("one_done_last",  out_last_o,  32'h0);
      checkOutput("one_done_busy",  busy_o,      32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
